// File: rtl/noc_vc_output_buffer.sv
// noc_vc_output_buffer: per-VC flit FIFOs with a round-robin, hold-stable output arbiter.
// Define NOC_VC_BUFFER_PACKET_LOCK_EN to keep HEADER..LAST packets contiguous (wormhole lock).
module noc_vc_output_buffer #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int VCHANNELS = 3,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [FLIT_DATA_WIDTH+FLIT_TYPE_WIDTH-1:0] in_flit,
  input  logic [VCHANNELS-1:0] in_valid,
  output logic [VCHANNELS-1:0] in_ready,
  output logic [FLIT_DATA_WIDTH+FLIT_TYPE_WIDTH-1:0] out_flit,
  output logic [VCHANNELS-1:0] out_valid,
  input  logic [VCHANNELS-1:0] out_ready
);
  localparam int FW = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int VW = VCHANNELS > 1 ? $clog2(VCHANNELS) : 1;
  localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, LOCKED = 2'd2;
  localparam logic [1:0] T_HEADER = 2'b01, T_LAST = 2'b10;
`ifdef NOC_VC_BUFFER_PACKET_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif
  logic [FW-1:0] mem_q [VCHANNELS][DEPTH];
  logic [AW-1:0] wr_ptr_q [VCHANNELS];
  logic [AW-1:0] rd_ptr_q [VCHANNELS];
  logic [CW-1:0] cnt_q [VCHANNELS];
  logic [1:0] state_q, state_d;
  logic [VW-1:0] grant_q, grant_d, rr_q, rr_d, hi_sel, lo_sel, sel, g;
  logic [VCHANNELS-1:0] empty, full, push, pop;
  logic hi_found, lo_found, any_valid, xfer, lock_hdr;
  logic [FW-1:0] head;
  logic [1:0] typ;
  always_comb begin
    for (int v = 0; v < VCHANNELS; v++) begin
      empty[v] = cnt_q[v] == '0;
      full[v] = cnt_q[v] == CW'(DEPTH);
    end
  end
  assign in_ready = ~full & {VCHANNELS{~rst}};
  assign push = in_valid & in_ready;
  // Downward scan keeps the lowest hit above rr_q and the lowest hit at/below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel = '0;
    lo_sel = '0;
    for (int v = VCHANNELS - 1; v >= 0; v--) begin
      if (!empty[v] && v > int'(rr_q)) begin
        hi_found = 1'b1;
        hi_sel = VW'(v);
      end else if (!empty[v]) begin
        lo_found = 1'b1;
        lo_sel = VW'(v);
      end
    end
  end
  assign sel = hi_found ? hi_sel : lo_sel;
  assign g = (state_q == IDLE) ? sel : grant_q;
  assign any_valid = ~rst & ((state_q == IDLE) ? (hi_found | lo_found) : ~empty[grant_q]);
  assign head = mem_q[g][rd_ptr_q[g]];
  assign typ = head[FW-1 -: 2];
  assign out_valid = any_valid ? VCHANNELS'(1) << g : '0;
  assign out_flit = any_valid ? head : '0;
  assign pop = out_valid & out_ready;
  assign xfer = |pop;
  assign lock_hdr = LOCK_EN & (typ == T_HEADER);
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    case (state_q)
      IDLE: if (any_valid) begin
        grant_d = g;
        if (!xfer) state_d = HOLD;
        else if (lock_hdr) state_d = LOCKED;
        else rr_d = g;
      end
      HOLD: if (xfer) begin
        state_d = lock_hdr ? LOCKED : IDLE;
        rr_d = lock_hdr ? rr_q : g;
      end
      LOCKED: if (xfer && typ == T_LAST) begin
        state_d = IDLE;
        rr_d = g;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q <= VW'(VCHANNELS - 1);
      for (int v = 0; v < VCHANNELS; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      for (int v = 0; v < VCHANNELS; v++) begin
        if (push[v]) begin
          mem_q[v][wr_ptr_q[v]] <= in_flit;
          wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
        end
        if (pop[v]) rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
        cnt_q[v] <= cnt_q[v] + CW'(push[v]) - CW'(pop[v]);
      end
    end
  end
endmodule

// File: tb/tb_noc_vc_output_buffer.sv
// tb_noc_vc_output_buffer: vector table plus per-VC ordered scoreboard and grant-order checks.
module tb_noc_vc_output_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [33:0] in_flit, out_flit;
  logic [2:0] in_valid, in_ready, out_valid, out_ready;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [1:0] vc; logic [33:0] flit;} sb_t;
  typedef struct {
    logic [2:0] iv;
    logic [33:0] fl;
    logic [2:0] ordy;
    bit acc;
    logic [2:0] eir;
    logic [2:0] eov;
    logic [33:0] eof;
  } vec_t;
  sb_t sbq[$];
  int got[$];
  vec_t vec[14];
  int mv, midx;
  int exp_rr[6] = '{0, 1, 2, 0, 1, 2};
`ifdef NOC_VC_BUFFER_PACKET_LOCK_EN
  int exp_lk[6] = '{0, 0, 0, 0, 2, 2};
  logic [2:0] exp_m5 = 3'b001, exp_m6 = 3'b000;
`else
  int exp_lk[6] = '{0, 2, 0, 2, 0, 0};
  logic [2:0] exp_m5 = 3'b010, exp_m6 = 3'b001;
`endif
  always #5 clk = ~clk;
  noc_vc_output_buffer dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int vc_of(input logic [2:0] oh);
    return oh[2] ? 2 : oh[1] ? 1 : 0;
  endfunction
  task automatic drive(input logic [2:0] oh, input logic [33:0] f, input bit acc);
    in_valid = oh;
    in_flit = f;
    if (acc) sbq.push_back({2'(vc_of(oh)), f});
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && sbq.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(sbq.size()), 0);
  endtask
  always @(posedge clk) assert ($onehot0(in_valid)) else $error("in_valid not one-hot: %b", in_valid);
  always @(negedge clk) if (!rst) begin
    chk("out_valid_onehot", 64'($onehot0(out_valid)), 1);
    if ((out_valid & out_ready) != 0) begin
      mv = vc_of(out_valid);
      midx = -1;
      for (int i = 0; i < sbq.size(); i++) if (midx < 0 && sbq[i].vc == 2'(mv)) midx = i;
      got.push_back(mv);
      if (midx < 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: vc %0d flit %0h with nothing pending", mv, out_flit);
      end else begin
        chk($sformatf("sb_flit_vc%0d", mv), out_flit, sbq[midx].flit);
        sbq.delete(midx);
      end
    end
  end
  initial begin
    in_valid = 0;
    in_flit = 0;
    out_ready = 0;
    vec[0]  = '{3'b010, 34'h3DEADBEEF, 3'b111, 1, 3'b111, 3'b000, 34'h0};
    vec[1]  = '{3'b000, 34'h0, 3'b111, 0, 3'b111, 3'b010, 34'h3DEADBEEF};
    vec[2]  = '{3'b000, 34'h0, 3'b111, 0, 3'b111, 3'b000, 34'h0};
    vec[3]  = '{3'b001, 34'h3000000A0, 3'b000, 1, 3'b111, 3'b000, 34'h0};
    vec[4]  = '{3'b001, 34'h3000000A1, 3'b000, 1, 3'b111, 3'b001, 34'h3000000A0};
    vec[5]  = '{3'b001, 34'h3000000A2, 3'b000, 1, 3'b111, 3'b001, 34'h3000000A0};
    vec[6]  = '{3'b001, 34'h3000000A3, 3'b000, 1, 3'b111, 3'b001, 34'h3000000A0};
    vec[7]  = '{3'b001, 34'h3000000A4, 3'b000, 0, 3'b110, 3'b001, 34'h3000000A0};
    vec[8]  = '{3'b000, 34'h0, 3'b000, 0, 3'b110, 3'b001, 34'h3000000A0};
    vec[9]  = '{3'b000, 34'h0, 3'b001, 0, 3'b110, 3'b001, 34'h3000000A0};
    vec[10] = '{3'b000, 34'h0, 3'b001, 0, 3'b111, 3'b001, 34'h3000000A1};
    vec[11] = '{3'b000, 34'h0, 3'b001, 0, 3'b111, 3'b001, 34'h3000000A2};
    vec[12] = '{3'b000, 34'h0, 3'b001, 0, 3'b111, 3'b001, 34'h3000000A3};
    vec[13] = '{3'b000, 34'h0, 3'b001, 0, 3'b111, 3'b000, 34'h0};
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flit", out_flit, 0);
    step;
    step;
    rst = 0;
    for (int k = 0; k < 14; k++) begin
      drive(vec[k].iv, vec[k].fl, vec[k].acc);
      out_ready = vec[k].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", k), in_ready, vec[k].eir);
      chk($sformatf("vec%0d_out_valid", k), out_valid, vec[k].eov);
      chk($sformatf("vec%0d_out_flit", k), out_flit, vec[k].eof);
      step;
    end
    in_valid = 0;
    got.delete();
    out_ready = 0;
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < 3; v++) begin
        drive(3'(1 << v), {2'b11, 32'(32'hB000 + r * 16 + v)}, 1);
        step;
      end
    in_valid = 0;
    out_ready = 3'b111;
    drain(40);
    chk("rr_count", 64'(got.size()), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("rr_grant%0d", i), 64'(got[i]), 64'(exp_rr[i]));
    out_ready = 0;
    drive(3'b010, {2'b11, 32'hC1}, 1);
    step;
    in_valid = 0;
    @(negedge clk);
    chk("hold_offer", out_valid, 3'b010);
    step;
    drive(3'b001, {2'b11, 32'hC0}, 1);
    @(negedge clk);
    chk("hold_keep0", out_valid, 3'b010);
    step;
    in_valid = 0;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold_keep%0d", i), out_valid, 3'b010);
      step;
    end
    out_ready = 3'b010;
    @(negedge clk);
    chk("hold_release", out_valid, 3'b010);
    step;
    @(negedge clk);
    chk("hold_next_valid", out_valid, 3'b001);
    chk("hold_next_flit", out_flit, {2'b11, 32'hC0});
    step;
    out_ready = 3'b111;
    drain(20);
    got.delete();
    out_ready = 0;
    drive(3'b001, {2'b01, 32'hD0}, 1); step;
    drive(3'b100, {2'b11, 32'hE1}, 1); step;
    drive(3'b001, {2'b00, 32'hD1}, 1); step;
    drive(3'b100, {2'b11, 32'hE2}, 1); step;
    drive(3'b001, {2'b00, 32'hD2}, 1); step;
    drive(3'b001, {2'b10, 32'hD3}, 1); step;
    in_valid = 0;
    out_ready = 3'b111;
    drain(40);
    chk("pkt_count", 64'(got.size()), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("pkt_grant%0d", i), 64'(got[i]), 64'(exp_lk[i]));
    out_ready = 0;
    drive(3'b001, {2'b01, 32'hF0}, 1); step;
    drive(3'b001, {2'b00, 32'hF1}, 1);
    @(negedge clk);
    chk("mid_hold", out_valid, 3'b001);
    step;
    drive(3'b010, {2'b11, 32'hF9}, 1); step;
    in_valid = 0;
    out_ready = 3'b111;
    @(negedge clk);
    chk("mid_hdr_valid", out_valid, 3'b001);
    chk("mid_hdr_flit", out_flit, {2'b01, 32'hF0});
    step;
    @(negedge clk);
    chk("mid_c5", out_valid, exp_m5);
    step;
    @(negedge clk);
    chk("mid_c6", out_valid, exp_m6);
    step;
    @(negedge clk);
    chk("mid_c7", out_valid, 3'b000);
    step;
    rst = 1;
    sbq.delete();
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_flit", out_flit, 0);
    step;
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 3'b111);
    chk("post_rst_valid", out_valid, 0);
    step;
    drive(3'b010, {2'b11, 32'h77}, 1);
    step;
    in_valid = 0;
    @(negedge clk);
    chk("post_rst_idle_valid", out_valid, 3'b010);
    chk("post_rst_idle_flit", out_flit, {2'b11, 32'h77});
    step;
    drain(20);
    chk("sb_empty", 64'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/noc_vc_output_buffer.md
# noc_vc_output_buffer

Per-virtual-channel flit buffer and output arbiter on the compute tile's NoC egress. It sits directly downstream of the tile's `noc_out_flit` / `noc_out_valid` / `noc_out_ready` port. It queues flits per VC and re-emits them on one shared flit bus with one-hot valid, toward the next router or tile input. Arbitration is round-robin across VCs and packet-atomic (wormhole lock) when configured.

## Interface
- `FLIT_DATA_WIDTH`, default 32: payload bits.
- `FLIT_TYPE_WIDTH`, default 2: type bits, located at the MSBs of the flit.
- `VCHANNELS`, default 3: number of virtual channels.
- `DEPTH`, default 4: entries per VC FIFO; power of two, ≥2.
- Local `FLIT_WIDTH` = `FLIT_DATA_WIDTH` + `FLIT_TYPE_WIDTH`.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `in_flit`, in, FLIT_WIDTH: flit from the tile's `noc_out_flit`.
- `in_valid`, in, VCHANNELS: per-VC valid; at most one bit set (producer contract, the bench asserts this).
- `in_ready`, out, VCHANNELS: per-VC ready.
- `out_flit`, out, FLIT_WIDTH: flit to the downstream input.
- `out_valid`, out, VCHANNELS: per-VC valid; at most one bit set.
- `out_ready`, in, VCHANNELS: downstream per-VC ready.

## Operation
- Flit type is `flit[FLIT_WIDTH-1 -: 2]`: 01 = HEADER, 00 = PAYLOAD, 10 = LAST, 11 = SINGLE.
- **Input side:** write to VC v when `in_valid[v] & in_ready[v]`. `in_ready[v] = ~full[v] & ~rst`. It does not depend on `in_valid` or on a same-cycle pop, so a full FIFO accepts nothing even when it is popped in the same cycle.
- **FIFOs:** circular, with read/write pointers and a count of width clog2(DEPTH)+1. Pointers wrap at DEPTH. Simultaneous push and pop leaves the count unchanged.
- **Output side:** `out_valid[g] = ~empty[g]` for the current grant g, otherwise 0. `out_flit` = head of FIFO g; it is all zeros when no bit of `out_valid` is set. A transfer happens on `out_valid[g] & out_ready[g]`.
- **Arbiter states:** IDLE, HOLD, LOCKED. A registered `rr_ptr` holds the last served VC.
  - **IDLE:** g = first non-empty VC searching from `rr_ptr+1`, modulo VCHANNELS.
    - Offer not accepted: go to HOLD with g captured.
    - HEADER transferred: go to LOCKED on g.
    - Any other type transferred: stay IDLE, `rr_ptr` ← g.
  - **HOLD:** g is fixed, so a valid offer is never withdrawn or switched while unaccepted.
    - HEADER transferred: go to LOCKED.
    - Other type transferred: go to IDLE, `rr_ptr` ← g.
  - **LOCKED:** g is fixed. If the locked FIFO is empty, `out_valid` = 0 and no other VC is served.
    - LAST transferred: go to IDLE, `rr_ptr` ← g.
    - HEADER/PAYLOAD/SINGLE transferred: stay LOCKED.
- PAYLOAD or LAST at a FIFO head while in IDLE/HOLD is forwarded as a single flit, with no lock taken.

## Timing
- **Reset values:** while `rst` is high, `in_ready` = 0, `out_valid` = 0, `out_flit` = 0. All FIFOs are empty, state is IDLE, and `rr_ptr` = VCHANNELS-1, so VC0 has first priority. `in_ready` = all ones in the first cycle after reset deasserts.
- Latency is 1 cycle: a flit written at edge N is offered at output from cycle N+1 (no combinational bypass). Sustained throughput is 1 flit/cycle.
- `out_valid`/`out_flit` are combinational from registered state only. There is no combinational path from `out_ready` or `in_valid` to any output.
- Reset asserted mid-packet: on the next edge, state goes to IDLE, FIFOs are flushed, and `rr_ptr` is reinitialised. Partial packets are dropped.

## Configuration
- `NOC_VC_BUFFER_PACKET_LOCK_EN` defined: HEADER enters LOCKED as described above; packets leave contiguously.
- Not defined: the LOCKED state is not built. A HEADER transfer behaves like SINGLE, i.e. the arbiter re-arbitrates round-robin after every flit and packets from different VCs interleave flit by flit. HOLD behaviour is unchanged.

## Test plan
- **Reset:** hold `rst` 2 cycles, then release → `in_ready` = 3'b111, `out_valid` = 3'b000, `out_flit` = 0.
- **Single-flit latency:** write `{2'b11, 32'hDEADBEEF}` on VC1 at edge N, `out_ready` = 3'b111 → at cycle N+1 `out_valid` = 3'b010 and `out_flit` = 34'h3DEADBEEF. At N+2 `out_valid` = 0.
- **Full:** `out_ready` = 0, write 4 flits to VC0 → `in_ready[0]` = 0 after the 4th write, and a 5th `in_valid[0]` is not accepted. `in_ready[2:1]` stays 1.
- **Round robin:** preload two SINGLE flits into each of VC0, VC1 and VC2, then set `out_ready` = 1 → grant order is 0,1,2,0,1,2.
- **Hold:** VC1 offered with `out_ready` = 0, then a SINGLE written to VC0 → `out_valid` stays 3'b010 until `out_ready[1]` = 1.
- **Packet lock (macro on):** write VC0 HEADER, PAYLOAD, PAYLOAD, LAST interleaved with two VC2 SINGLEs, `out_ready` = 1 → all four VC0 flits leave contiguously, then the VC2 flits. Assert `rst` mid-packet → next cycle `out_valid` = 0 and state is IDLE.
